// File: rtl/axi_arb_pkg.sv
// Shared types for the two-to-one AXI4 memory arbiter.
// Request payload widths, round-robin encoding, counter helper.
package axi_arb_pkg;

    localparam int IDX_W = 1;

    // len + size + burst + lock + cache + prot + qos
    localparam int AX_FIXED_W = 8 + 3 + 2 + 1 + 4 + 3 + 4;

    function automatic int ax_req_w(int id_w, int addr_w);
        return id_w + addr_w + AX_FIXED_W;
    endfunction

    // Records which source won the most recent grant.
    typedef enum logic [IDX_W-1:0] {
        RR_S0 = 1'b0,
        RR_S1 = 1'b1
    } rr_ptr_e;

    function automatic logic [15:0] sat_add(
        logic [15:0] a,
        logic [1:0]  b
    );
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// Full AXI4 bundle (aw/w/b/ar/r) with master and slave modports.
// ID_W/ADDR_W/DATA_W size the id, address and data fields.
interface axi_mem_arbiter_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 36,
    parameter int DATA_W = 64
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst,
        input  awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_rr_req_slice.sv
// Two-way round-robin request picker feeding one holding register.
// Ports: clk, reset, en (grant gate), req_valid/req_data/req_ready
// per source, out_valid/out_data/out_ready toward the memory port.
module axi_rr_req_slice
    import axi_arb_pkg::*;
#(
    parameter int PW = 61
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [1:0]            req_valid,
    input  logic [1:0][PW-1:0]    req_data,
    output logic [1:0]            req_ready,
    output logic                  out_valid,
    output logic [PW+IDX_W-1:0]   out_data,
    input  logic                  out_ready
);
    rr_ptr_e last_q;
    logic    load;
    logic    win;

    // Register can take a new request when empty or draining now.
    assign load = (!out_valid || out_ready) && en && !reset;

    // s1 wins alone, or on contention when s0 won last time.
    assign win = req_valid[1] && (!req_valid[0] || last_q == RR_S0);

    assign req_ready[0] = load && req_valid[0] && !win;
    assign req_ready[1] = load && win;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            last_q    <= RR_S0;
        end else if (|req_ready) begin
            out_valid <= 1'b1;
            out_data  <= {win, req_data[win]};
            last_q    <= rr_ptr_e'(win);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Two-to-one AXI4 arbiter sharing one memory port between s0 and s1.
// Ports: clk, reset, s0_axi/s1_axi (slave), m_axi (master), grant_cnt0/1.
module axi_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 36,
    parameter int DATA_W   = 64,
    parameter int WQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    axi_mem_arbiter_if.slave    s0_axi,
    axi_mem_arbiter_if.slave    s1_axi,
    axi_mem_arbiter_if.master   m_axi,
    output logic [15:0]         grant_cnt0,
    output logic [15:0]         grant_cnt1
);
    localparam int PW = ax_req_w(ID_W, ADDR_W);
    localparam int QW = $clog2(WQ_DEPTH);

    logic [1:0][PW-1:0]    ar_req, aw_req;
    logic [1:0]            ar_gnt, aw_gnt;
    logic [PW+IDX_W-1:0]   ar_out, aw_out;
    logic                  ar_vld, aw_vld;

    logic [WQ_DEPTH-1:0]   wq_mem;
    logic [QW-1:0]         wq_wr, wq_rd;
    logic [QW:0]           wq_cnt;
    logic                  wq_full, wq_empty, wq_head;
    logic                  wq_push, wq_pop;
    logic                  r_idx, b_idx;

    // ---------------- AR / AW ----------------
    assign ar_req[0] = {s0_axi.arid, s0_axi.araddr, s0_axi.arlen,
                        s0_axi.arsize, s0_axi.arburst, s0_axi.arlock,
                        s0_axi.arcache, s0_axi.arprot, s0_axi.arqos};
    assign ar_req[1] = {s1_axi.arid, s1_axi.araddr, s1_axi.arlen,
                        s1_axi.arsize, s1_axi.arburst, s1_axi.arlock,
                        s1_axi.arcache, s1_axi.arprot, s1_axi.arqos};
    assign aw_req[0] = {s0_axi.awid, s0_axi.awaddr, s0_axi.awlen,
                        s0_axi.awsize, s0_axi.awburst, s0_axi.awlock,
                        s0_axi.awcache, s0_axi.awprot, s0_axi.awqos};
    assign aw_req[1] = {s1_axi.awid, s1_axi.awaddr, s1_axi.awlen,
                        s1_axi.awsize, s1_axi.awburst, s1_axi.awlock,
                        s1_axi.awcache, s1_axi.awprot, s1_axi.awqos};

    axi_rr_req_slice #(.PW(PW)) u_ar (
        .clk       (clk),
        .reset     (reset),
        .en        (1'b1),
        .req_valid ({s1_axi.arvalid, s0_axi.arvalid}),
        .req_data  (ar_req),
        .req_ready (ar_gnt),
        .out_valid (ar_vld),
        .out_data  (ar_out),
        .out_ready (m_axi.arready)
    );

    // AW grants stall while the W order queue is full.
    axi_rr_req_slice #(.PW(PW)) u_aw (
        .clk       (clk),
        .reset     (reset),
        .en        (!wq_full),
        .req_valid ({s1_axi.awvalid, s0_axi.awvalid}),
        .req_data  (aw_req),
        .req_ready (aw_gnt),
        .out_valid (aw_vld),
        .out_data  (aw_out),
        .out_ready (m_axi.awready)
    );

    assign s0_axi.arready = ar_gnt[0];
    assign s1_axi.arready = ar_gnt[1];
    assign s0_axi.awready = aw_gnt[0];
    assign s1_axi.awready = aw_gnt[1];

    // Index sits directly above the id, so it becomes the id MSB.
    assign m_axi.arvalid = ar_vld;
    assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize,
            m_axi.arburst, m_axi.arlock, m_axi.arcache,
            m_axi.arprot, m_axi.arqos} = ar_out;
    assign m_axi.awvalid = aw_vld;
    assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize,
            m_axi.awburst, m_axi.awlock, m_axi.awcache,
            m_axi.awprot, m_axi.awqos} = aw_out;

    // ---------------- W order queue ----------------
    assign wq_full  = wq_cnt == (QW+1)'(WQ_DEPTH);
    assign wq_empty = wq_cnt == '0;
    assign wq_head  = wq_mem[wq_rd];
    assign wq_push  = |aw_gnt;
    assign wq_pop   = m_axi.wvalid && m_axi.wready && m_axi.wlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            wq_mem <= '0;
            wq_wr  <= '0;
            wq_rd  <= '0;
            wq_cnt <= '0;
        end else begin
            if (wq_push) begin
                wq_mem[wq_wr] <= aw_gnt[1];
                wq_wr         <= wq_wr + 1'b1;
            end
            if (wq_pop) begin
                wq_rd <= wq_rd + 1'b1;
            end
            case ({wq_push, wq_pop})
                2'b10:   wq_cnt <= wq_cnt + 1'b1;
                2'b01:   wq_cnt <= wq_cnt - 1'b1;
                default: wq_cnt <= wq_cnt;
            endcase
        end
    end

    assign m_axi.wvalid = !wq_empty &&
                          (wq_head ? s1_axi.wvalid : s0_axi.wvalid);
    assign m_axi.wdata  = wq_head ? s1_axi.wdata : s0_axi.wdata;
    assign m_axi.wstrb  = wq_head ? s1_axi.wstrb : s0_axi.wstrb;
    assign m_axi.wlast  = wq_head ? s1_axi.wlast : s0_axi.wlast;
    assign s0_axi.wready = !wq_empty && !wq_head && m_axi.wready;
    assign s1_axi.wready = !wq_empty &&  wq_head && m_axi.wready;

    // ---------------- R / B steering ----------------
    assign r_idx = m_axi.rid[ID_W];
    assign b_idx = m_axi.bid[ID_W];

    assign s0_axi.rvalid = m_axi.rvalid && !r_idx;
    assign s1_axi.rvalid = m_axi.rvalid &&  r_idx;
    assign s0_axi.rid    = m_axi.rid[ID_W-1:0];
    assign s1_axi.rid    = m_axi.rid[ID_W-1:0];
    assign s0_axi.rdata  = m_axi.rdata;
    assign s1_axi.rdata  = m_axi.rdata;
    assign s0_axi.rresp  = m_axi.rresp;
    assign s1_axi.rresp  = m_axi.rresp;
    assign s0_axi.rlast  = m_axi.rlast;
    assign s1_axi.rlast  = m_axi.rlast;
    assign m_axi.rready  = r_idx ? s1_axi.rready : s0_axi.rready;

    assign s0_axi.bvalid = m_axi.bvalid && !b_idx;
    assign s1_axi.bvalid = m_axi.bvalid &&  b_idx;
    assign s0_axi.bid    = m_axi.bid[ID_W-1:0];
    assign s1_axi.bid    = m_axi.bid[ID_W-1:0];
    assign s0_axi.bresp  = m_axi.bresp;
    assign s1_axi.bresp  = m_axi.bresp;
    assign m_axi.bready  = b_idx ? s1_axi.bready : s0_axi.bready;

    // ---------------- grant counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            grant_cnt0 <= sat_add(grant_cnt0,
                                  {1'b0, ar_gnt[0]} + {1'b0, aw_gnt[0]});
            grant_cnt1 <= sat_add(grant_cnt1,
                                  {1'b0, ar_gnt[1]} + {1'b0, aw_gnt[1]});
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed scoreboard bench for axi_mem_arbiter.
// Expected AR/AW/W beats are queued at grant time, checked at m side.
module tb_axi_mem_arbiter;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] grant_cnt0, grant_cnt1;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;
    bit last_ar = 1'b0;
    bit w;

    logic [127:0] ar_q[$];
    logic [127:0] aw_q[$];
    logic [127:0] w_q[$];

    axi_mem_arbiter_if #(.ID_W(4), .ADDR_W(36), .DATA_W(64)) s0_if ();
    axi_mem_arbiter_if #(.ID_W(4), .ADDR_W(36), .DATA_W(64)) s1_if ();
    axi_mem_arbiter_if #(.ID_W(5), .ADDR_W(36), .DATA_W(64)) m_if ();

    axi_mem_arbiter #(
        .ID_W(4), .ADDR_W(36), .DATA_W(64), .WQ_DEPTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s0_axi     (s0_if.slave),
        .s1_axi     (s1_if.slave),
        .m_axi      (m_if.master),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ax(logic [4:0] id,
                                        logic [35:0] a,
                                        logic [7:0] len);
        return {75'd0, id, a, len};
    endfunction

    function automatic logic [127:0] wb(logic [63:0] d, logic last);
        return {55'd0, d, 8'hFF, last};
    endfunction

    // m-side monitors: handshakes complete at the following posedge.
    always @(negedge clk) begin
        if (m_if.arvalid === 1'b1 && m_if.arready === 1'b1) begin
            if (ar_q.size() == 0)
                chk("ar_unexpected", 128'(ar_q.size()), 128'd1);
            else
                chk("m_ar", ax(m_if.arid, m_if.araddr, m_if.arlen),
                    ar_q.pop_front());
        end
        if (m_if.awvalid === 1'b1 && m_if.awready === 1'b1) begin
            if (aw_q.size() == 0)
                chk("aw_unexpected", 128'(aw_q.size()), 128'd1);
            else
                chk("m_aw", ax(m_if.awid, m_if.awaddr, m_if.awlen),
                    aw_q.pop_front());
        end
        if (m_if.wvalid === 1'b1 && m_if.wready === 1'b1) begin
            if (w_q.size() == 0)
                chk("w_unexpected", 128'(w_q.size()), 128'd1);
            else
                chk("m_w", {55'd0, m_if.wdata, m_if.wstrb, m_if.wlast},
                    w_q.pop_front());
        end
    end

    initial begin
        s0_if.awvalid = 0; s0_if.awid = 0; s0_if.awaddr = 0;
        s0_if.awlen = 0; s0_if.awsize = 3; s0_if.awburst = 1;
        s0_if.awlock = 0; s0_if.awcache = 0; s0_if.awprot = 0;
        s0_if.awqos = 0; s0_if.wvalid = 0; s0_if.wdata = 0;
        s0_if.wstrb = 8'hFF; s0_if.wlast = 0; s0_if.bready = 0;
        s0_if.arvalid = 0; s0_if.arid = 0; s0_if.araddr = 0;
        s0_if.arlen = 0; s0_if.arsize = 3; s0_if.arburst = 1;
        s0_if.arlock = 0; s0_if.arcache = 0; s0_if.arprot = 0;
        s0_if.arqos = 0; s0_if.rready = 0;
        s1_if.awvalid = 0; s1_if.awid = 0; s1_if.awaddr = 0;
        s1_if.awlen = 0; s1_if.awsize = 3; s1_if.awburst = 1;
        s1_if.awlock = 0; s1_if.awcache = 0; s1_if.awprot = 0;
        s1_if.awqos = 0; s1_if.wvalid = 0; s1_if.wdata = 0;
        s1_if.wstrb = 8'hFF; s1_if.wlast = 0; s1_if.bready = 0;
        s1_if.arvalid = 0; s1_if.arid = 0; s1_if.araddr = 0;
        s1_if.arlen = 0; s1_if.arsize = 3; s1_if.arburst = 1;
        s1_if.arlock = 0; s1_if.arcache = 0; s1_if.arprot = 0;
        s1_if.arqos = 0; s1_if.rready = 0;
        m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0;
        m_if.bid = 0; m_if.bresp = 0; m_if.arready = 0;
        m_if.rvalid = 0; m_if.rid = 0; m_if.rdata = 0;
        m_if.rresp = 0; m_if.rlast = 0;

        // reset state
        reset = 1'b1;
        repeat (2) tick;
        chk("rst_valids", {m_if.arvalid, m_if.awvalid, m_if.wvalid,
                           s0_if.rvalid, s1_if.bvalid,
                           s0_if.arready, s1_if.awready}, 0);
        chk("rst_cnt", {grant_cnt0, grant_cnt1}, 0);
        reset = 1'b0;
        tick;

        // single AR from s0, then 8 R beats routed to s0 only
        s0_if.arvalid = 1; s0_if.arid = 4'h3;
        s0_if.araddr = 36'h0_8000_1000; s0_if.arlen = 8'd7;
        #1 chk("ar1_ready", s0_if.arready, 1);
        ar_q.push_back(ax(5'h03, 36'h0_8000_1000, 8'd7));
        exp_cnt0++;
        tick;
        s0_if.arvalid = 0;
        #1 chk("ar1_m", {m_if.arvalid, m_if.arid, m_if.araddr},
                        {1'b1, 5'h03, 36'h0_8000_1000});
        tick;
        chk("ar1_hold", {m_if.arvalid, m_if.arid}, {1'b1, 5'h03});
        m_if.arready = 1;
        tick;
        m_if.arready = 0;
        s0_if.rready = 1;
        for (int i = 0; i < 8; i++) begin
            m_if.rvalid = 1; m_if.rid = 5'h03;
            m_if.rdata = 64'hA000 + 64'(i); m_if.rlast = (i == 7);
            #1 chk("r_route",
                   {s0_if.rvalid, s1_if.rvalid, s0_if.rid,
                    s0_if.rdata, s0_if.rlast, m_if.rready},
                   {1'b1, 1'b0, 4'h3, 64'hA000 + 64'(i),
                    (i == 7), 1'b1});
            tick;
        end
        m_if.rvalid = 0; s0_if.rready = 0;

        // contended AR: alternating grants
        m_if.arready = 1;
        s0_if.arvalid = 1; s0_if.arid = 4'h1;
        s0_if.araddr = 36'h1000; s0_if.arlen = 0;
        s1_if.arvalid = 1; s1_if.arid = 4'h2;
        s1_if.araddr = 36'h2000; s1_if.arlen = 1;
        for (int k = 0; k < 6; k++) begin
            w = !last_ar;
            #1 chk("ar_rr", {s1_if.arready, s0_if.arready},
                   w ? 2'b10 : 2'b01);
            if (w) begin
                ar_q.push_back(ax(5'h12, 36'h2000, 8'd1));
                exp_cnt1++;
            end else begin
                ar_q.push_back(ax(5'h01, 36'h1000, 8'd0));
                exp_cnt0++;
            end
            last_ar = w;
            tick;
        end
        s0_if.arvalid = 0; s1_if.arvalid = 0;
        #1 chk("cnt_rr", {grant_cnt0, grant_cnt1},
               {16'(exp_cnt0), 16'(exp_cnt1)});
        tick;
        m_if.arready = 0;

        // W ordering follows AW grant order
        m_if.awready = 1; m_if.wready = 1;
        s0_if.awvalid = 1; s0_if.awid = 4'h4;
        s0_if.awaddr = 36'h3000; s0_if.awlen = 3;
        s1_if.wvalid = 1; s1_if.wdata = 64'h100; s1_if.wlast = 0;
        #1 chk("w_empty", {m_if.wvalid, s1_if.wready}, 0);
        chk("aw0_ready", s0_if.awready, 1);
        aw_q.push_back(ax(5'h04, 36'h3000, 8'd3));
        exp_cnt0++;
        tick;
        s0_if.awvalid = 0;
        s1_if.awvalid = 1; s1_if.awid = 4'h5;
        s1_if.awaddr = 36'h4000; s1_if.awlen = 3;
        #1 chk("aw1_ready", s1_if.awready, 1);
        chk("w_block", {m_if.wvalid, s1_if.wready}, 0);
        aw_q.push_back(ax(5'h15, 36'h4000, 8'd3));
        exp_cnt1++;
        tick;
        s1_if.awvalid = 0;
        for (int k = 0; k < 4; k++) begin
            s0_if.wvalid = 1; s0_if.wdata = 64'h200 + 64'(k);
            s0_if.wlast = (k == 3);
            #1 chk("w_s0", {s0_if.wready, s1_if.wready}, 2'b10);
            w_q.push_back(wb(64'h200 + 64'(k), k == 3));
            tick;
        end
        s0_if.wvalid = 0;
        for (int k = 0; k < 4; k++) begin
            s1_if.wdata = 64'h100 + 64'(k); s1_if.wlast = (k == 3);
            #1 chk("w_s1", {s0_if.wready, s1_if.wready}, 2'b01);
            w_q.push_back(wb(64'h100 + 64'(k), k == 3));
            tick;
        end
        s0_if.wvalid = 1; s0_if.wlast = 1;
        #1 chk("w_drained",
               {m_if.wvalid, s0_if.wready, s1_if.wready}, 0);
        s0_if.wvalid = 0; s1_if.wvalid = 0;

        // W queue full blocks the fifth AW until a wlast pops
        m_if.wready = 0;
        s0_if.awvalid = 1; s0_if.awid = 4'h6;
        s0_if.awaddr = 36'h5000; s0_if.awlen = 0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("aw_fill", s0_if.awready, 1);
            aw_q.push_back(ax(5'h06, 36'h5000, 8'd0));
            exp_cnt0++;
            tick;
        end
        chk("aw_full", s0_if.awready, 0);
        tick;
        chk("aw_full2", s0_if.awready, 0);
        s0_if.wvalid = 1; s0_if.wdata = 64'h300; s0_if.wlast = 1;
        m_if.wready = 1;
        #1 chk("w_pop", s0_if.wready, 1);
        chk("aw_full3", s0_if.awready, 0);
        w_q.push_back(wb(64'h300, 1'b1));
        tick;
        s0_if.wvalid = 0;
        #1 chk("aw_refill", s0_if.awready, 1);
        aw_q.push_back(ax(5'h06, 36'h5000, 8'd0));
        exp_cnt0++;
        tick;
        s0_if.awvalid = 0;
        for (int k = 0; k < 4; k++) begin
            s0_if.wvalid = 1; s0_if.wdata = 64'h310 + 64'(k);
            #1 chk("w_drain", s0_if.wready, 1);
            w_q.push_back(wb(64'h310 + 64'(k), 1'b1));
            tick;
        end
        s0_if.wvalid = 0; m_if.wready = 0;

        // B steering by id MSB
        m_if.bvalid = 1; m_if.bid = 5'h1A; m_if.bresp = 2'b10;
        s1_if.bready = 0; s0_if.bready = 1;
        #1 chk("b_wait", {s1_if.bvalid, s0_if.bvalid, m_if.bready},
               3'b100);
        s1_if.bready = 1;
        #1 chk("b_done", {s1_if.bvalid, m_if.bready,
                          s1_if.bid, s1_if.bresp},
               {1'b1, 1'b1, 4'hA, 2'b10});
        tick;
        m_if.bid = 5'h05; s1_if.bready = 0;
        #1 chk("b_s0", {s0_if.bvalid, s1_if.bvalid,
                        s0_if.bid, m_if.bready},
               {1'b1, 1'b0, 4'h5, 1'b1});
        tick;
        m_if.bvalid = 0; s0_if.bready = 0;

        // dual AR+AW grant, then reset with state in flight
        m_if.awready = 1;
        s0_if.arvalid = 1; s0_if.arid = 4'h7;
        s0_if.araddr = 36'h6000; s0_if.arlen = 0;
        s0_if.awvalid = 1; s0_if.awid = 4'h7;
        s0_if.awaddr = 36'h7000; s0_if.awlen = 1;
        #1 chk("dual_gnt", {s0_if.arready, s0_if.awready}, 2'b11);
        aw_q.push_back(ax(5'h07, 36'h7000, 8'd1));
        exp_cnt0 += 2;
        tick;
        s0_if.arvalid = 0;
        #1 chk("cnt_dual", grant_cnt0, 16'(exp_cnt0));
        aw_q.push_back(ax(5'h07, 36'h7000, 8'd1));
        exp_cnt0++;
        tick;
        s0_if.awvalid = 0;
        reset = 1;
        #1 chk("ar_pending", m_if.arvalid, 1);
        tick;
        s0_if.wvalid = 1; s0_if.wlast = 1; s0_if.wdata = 64'h400;
        m_if.wready = 1;
        #1 chk("rst_clear", {m_if.arvalid, m_if.awvalid, m_if.wvalid,
                             s0_if.wready, grant_cnt0, grant_cnt1}, 0);
        reset = 0;
        s0_if.wvalid = 0; m_if.wready = 0;
        exp_cnt0 = 0; exp_cnt1 = 0;
        tick;
        s0_if.arvalid = 1; s0_if.arid = 4'h1;
        s0_if.araddr = 36'h1000; s0_if.arlen = 0;
        s1_if.arvalid = 1; s1_if.arid = 4'h2;
        s1_if.araddr = 36'h2000; s1_if.arlen = 1;
        #1 chk("rst_rr", {s1_if.arready, s0_if.arready}, 2'b10);
        ar_q.push_back(ax(5'h12, 36'h2000, 8'd1));
        exp_cnt1++;
        m_if.arready = 1;
        tick;
        s0_if.arvalid = 0; s1_if.arvalid = 0;
        repeat (2) tick;
        chk("cnt_final", {grant_cnt0, grant_cnt1},
            {16'(exp_cnt0), 16'(exp_cnt1)});
        chk("q_empty", {32'(ar_q.size()), 32'(aw_q.size()),
                        32'(w_q.size())}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
